// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: 2-bit saturating counters indexed by PC xor committed global
// history, with zero-latency prediction and resolved/mispredicted performance counters.
module branch_predictor_gshare #(
   parameter int INDEX_BITS = 10,
   parameter int HIST_BITS  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pred_en,
   input  logic [14:0] pred_pc,
   input  logic        rslt_en,
   input  logic [14:0] rslt_pc,
   input  logic        rslt_taken,
   output logic        pred_taken,
   output logic [31:0] rslt_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int DEPTH = 1 << INDEX_BITS;

   logic [1:0]            tbl_reg [DEPTH];
   logic [INDEX_BITS-1:0] hist_mix;
   logic [INDEX_BITS-1:0] pred_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [1:0]            upd_cur;
   logic [1:0]            upd_next;
   logic                  upd_mispred;
   logic [31:0]           rslt_cnt_reg;
   logic [31:0]           mispred_cnt_reg;
   logic                  unused_bits;

   // pred_en only qualifies the request; the prediction is always driven.
   assign unused_bits = ^{pred_en, pred_pc, rslt_pc};

   generate
      if (HIST_BITS == 0) begin : g_no_hist
         assign hist_mix = '0;
      end else begin : g_hist
         logic [HIST_BITS-1:0] ghr_reg;
         logic [HIST_BITS-1:0] ghr_next;

         if (HIST_BITS == 1) begin : g_one
            assign ghr_next = rslt_taken;
         end else begin : g_shift
            assign ghr_next = {ghr_reg[HIST_BITS-2:0], rslt_taken};
         end

         // History is committed only from resolved branches, never from predictions.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ghr_reg <= '0;
            end else if (rslt_en) begin
               ghr_reg <= ghr_next;
            end
         end

         assign hist_mix = INDEX_BITS'(ghr_reg);
      end
   endgenerate

   assign pred_idx   = pred_pc[INDEX_BITS-1:0] ^ hist_mix;
   assign pred_taken = tbl_reg[pred_idx][1];

   assign upd_idx     = rslt_pc[INDEX_BITS-1:0] ^ hist_mix;
   assign upd_cur     = tbl_reg[upd_idx];
   assign upd_mispred = (upd_cur[1] != rslt_taken);

   always_comb begin
      upd_next = upd_cur;
      if (rslt_taken) begin
         if (upd_cur != 2'b11) begin
            upd_next = upd_cur + 2'd1;
         end
      end else if (upd_cur != 2'b00) begin
         upd_next = upd_cur - 2'd1;
      end
   end

   // All entries start weakly not-taken; no read bypass, so updates show next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_reg[i] <= 2'b01;
         end
      end else if (rslt_en) begin
         tbl_reg[upd_idx] <= upd_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rslt_cnt_reg    <= '0;
         mispred_cnt_reg <= '0;
      end else if (rslt_en) begin
         rslt_cnt_reg <= rslt_cnt_reg + 32'd1;
         if (upd_mispred) begin
            mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
         end
      end
   end

   assign rslt_cnt    = rslt_cnt_reg;
   assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a gshare instance (4,2) and a bimodal instance (4,0)
// share stimulus; a reference model feeds a scoreboard queue checked each cycle.
module tb_branch_predictor_gshare;

   logic        clk = 1'b0;
   logic        reset;
   logic        pred_en;
   logic [14:0] pred_pc;
   logic        rslt_en;
   logic [14:0] rslt_pc;
   logic        rslt_taken;
   logic        pred_taken_g, pred_taken_b;
   logic [31:0] rslt_cnt_g, rslt_cnt_b;
   logic [31:0] mispred_cnt_g, mispred_cnt_b;

   int checks = 0;
   int errors = 0;

   always #50 clk = ~clk;

   branch_predictor_gshare #(.INDEX_BITS(4), .HIST_BITS(2)) dut (
      .clk(clk), .reset(reset), .pred_en(pred_en), .pred_pc(pred_pc),
      .rslt_en(rslt_en), .rslt_pc(rslt_pc), .rslt_taken(rslt_taken),
      .pred_taken(pred_taken_g), .rslt_cnt(rslt_cnt_g), .mispred_cnt(mispred_cnt_g)
   );

   branch_predictor_gshare #(.INDEX_BITS(4), .HIST_BITS(0)) dut_bm (
      .clk(clk), .reset(reset), .pred_en(pred_en), .pred_pc(pred_pc),
      .rslt_en(rslt_en), .rslt_pc(rslt_pc), .rslt_taken(rslt_taken),
      .pred_taken(pred_taken_b), .rslt_cnt(rslt_cnt_b), .mispred_cnt(mispred_cnt_b)
   );

   // Reference model
   logic [1:0]  m_tbl [16];
   logic [1:0]  b_tbl [16];
   logic [1:0]  m_ghr;
   logic [31:0] m_rcnt, m_mis, b_mis;

   typedef struct packed {
      logic        p_main;
      logic        p_bm;
      logic [31:0] rcnt;
      logic [31:0] m_mis;
      logic [31:0] b_mis;
   } exp_t;

   exp_t sb_q[$];

   function automatic logic [3:0] m_idx(input logic [14:0] pc);
      return pc[3:0] ^ {2'b00, m_ghr};
   endfunction

   function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
      if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
      return (c == 2'b00) ? 2'b00 : c - 2'd1;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_tbl[i] = 2'b01;
         b_tbl[i] = 2'b01;
      end
      m_ghr  = 2'b00;
      m_rcnt = 0;
      m_mis  = 0;
      b_mis  = 0;
   endtask

   task automatic model_update(input logic ren, input logic [14:0] rpc, input logic rt);
      logic [3:0] u;
      logic [3:0] ub;
      if (ren) begin
         u  = m_idx(rpc);
         ub = rpc[3:0];
         if (m_tbl[u][1] != rt) m_mis++;
         if (b_tbl[ub][1] != rt) b_mis++;
         m_tbl[u]  = sat(m_tbl[u], rt);
         b_tbl[ub] = sat(b_tbl[ub], rt);
         m_ghr     = {m_ghr[0], rt};
         m_rcnt++;
      end
   endtask

   // One cycle: drive at negedge, check pre-edge outputs, let the edge commit the update.
   task automatic step(input logic ren, input logic [14:0] rpc, input logic rt, input logic [14:0] ppc);
      exp_t e;
      pred_en    = 1'b1;
      pred_pc    = ppc;
      rslt_en    = ren;
      rslt_pc    = rpc;
      rslt_taken = rt;
      e.p_main = m_tbl[m_idx(ppc)][1];
      e.p_bm   = b_tbl[ppc[3:0]][1];
      e.rcnt   = m_rcnt;
      e.m_mis  = m_mis;
      e.b_mis  = b_mis;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      check("pred_g", pred_taken_g, e.p_main);
      check("pred_b", pred_taken_b, e.p_bm);
      check("rcnt_g", rslt_cnt_g, e.rcnt);
      check("rcnt_b", rslt_cnt_b, e.rcnt);
      check("mis_g", mispred_cnt_g, e.m_mis);
      check("mis_b", mispred_cnt_b, e.b_mis);
      $display("txn ren=%0b rpc=%0d rt=%0b ppc=%0d pred_g=%0b pred_b=%0b rcnt=%0d mis_g=%0d mis_b=%0d",
               ren, rpc, rt, ppc, pred_taken_g, pred_taken_b, rslt_cnt_g, mispred_cnt_g, mispred_cnt_b);
      @(posedge clk);
      model_update(ren, rpc, rt);
      @(negedge clk);
      rslt_en = 1'b0;
   endtask

   task automatic peek_main(input string tag, input logic [14:0] ppc, input logic exp_v);
      pred_pc = ppc;
      #1;
      check(tag, pred_taken_g, exp_v);
   endtask

   task automatic peek_bm(input string tag, input logic [14:0] ppc, input logic exp_v);
      pred_pc = ppc;
      #1;
      check(tag, pred_taken_b, exp_v);
   endtask

   // Assert reset away from an edge; everything must clear before the next clk edge.
   task automatic do_reset(input string tag);
      reset   = 1'b1;
      rslt_en = 1'b0;
      model_reset();
      for (int p = 0; p < 16; p++) begin
         pred_pc = 15'(p);
         #1;
         check({tag, "_pred_g"}, pred_taken_g, 1'b0);
         check({tag, "_pred_b"}, pred_taken_b, 1'b0);
      end
      check({tag, "_rcnt_g"}, rslt_cnt_g, 32'd0);
      check({tag, "_rcnt_b"}, rslt_cnt_b, 32'd0);
      check({tag, "_mis_g"}, mispred_cnt_g, 32'd0);
      check({tag, "_mis_b"}, mispred_cnt_b, 32'd0);
      $display("txn reset %s", tag);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] pc;
      reset      = 1'b1;
      pred_en    = 1'b0;
      pred_pc    = '0;
      rslt_en    = 1'b0;
      rslt_pc    = '0;
      rslt_taken = 1'b0;
      model_reset();
      @(negedge clk);

      // Reset sweep
      do_reset("t1");

      // Bimodal learning on pc 5
      step(1'b1, 15'd5, 1'b1, 15'd5);
      peek_bm("t2_after1", 15'd5, 1'b1);
      step(1'b1, 15'd5, 1'b1, 15'd5);
      step(1'b1, 15'd5, 1'b1, 15'd5);
      check("t2_mis3T", mispred_cnt_b, 32'd1);
      check("t2_rcnt", rslt_cnt_b, 32'd3);
      step(1'b1, 15'd5, 1'b0, 15'd5);
      peek_bm("t2_nt1", 15'd5, 1'b1);
      check("t2_mis_nt1", mispred_cnt_b, 32'd2);
      step(1'b1, 15'd5, 1'b0, 15'd5);
      peek_bm("t2_nt2", 15'd5, 1'b0);
      check("t2_mis_nt2", mispred_cnt_b, 32'd3);

      // Saturation at strong not-taken on pc 3
      for (int i = 0; i < 5; i++) step(1'b1, 15'd3, 1'b0, 15'd3);
      check("t3_mis_sat", mispred_cnt_b, 32'd3);
      step(1'b1, 15'd3, 1'b1, 15'd3);
      check("t3_mis_t", mispred_cnt_b, 32'd4);
      peek_bm("t3_pred01", 15'd3, 1'b0);
      step(1'b1, 15'd3, 1'b1, 15'd3);
      peek_bm("t3_pred10", 15'd3, 1'b1);
      check("t3_rcnt", rslt_cnt_b, 32'd12);

      // History indexing
      do_reset("t4r");
      step(1'b1, 15'd1, 1'b1, 15'd0);
      step(1'b1, 15'd1, 1'b1, 15'd0);
      peek_main("t4_pc1", 15'd1, 1'b0);
      peek_main("t4_pc2", 15'd2, 1'b1);
      peek_main("t4_pc3", 15'd3, 1'b1);
      peek_main("t4_alias", 15'h4022, 1'b1);
      peek_bm("t4_bm_pc1", 15'd1, 1'b1);

      // Same-cycle prediction and update: no bypass
      do_reset("t5r");
      rslt_en    = 1'b1;
      rslt_pc    = 15'd7;
      rslt_taken = 1'b1;
      peek_bm("t5_same_b", 15'd7, 1'b0);
      peek_main("t5_same_g", 15'd7, 1'b0);
      step(1'b1, 15'd7, 1'b1, 15'd7);
      peek_bm("t5_next_b", 15'd7, 1'b1);
      peek_main("t5_next_g", 15'd6, 1'b1);

      // Random updates, mid-stream reset, then a long random run
      for (int i = 0; i < 20; i++) begin
         pc = 15'($urandom_range(0, 32767));
         step(1'b1, pc, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 15)));
      end
      do_reset("t6r");
      for (int i = 0; i < 250; i++) begin
         pc = 15'($urandom_range(0, 32767));
         step(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
              15'($urandom_range(0, 32767)));
      end
      check("t6_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
